// File: rtl/lagd_pkg.sv
// Shared types and constants for the LAGD Ising cluster front end.
package lagd_pkg;

  // Register-interface request/response used on the host and core ports.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  // Local CSR byte offsets inside the cluster-control window.
  localparam logic [7:0] CsrMaskOff   = 8'h0;
  localparam logic [7:0] CsrStatusOff = 8'h4;
  localparam logic [7:0] CsrIrqEnOff  = 8'h8;

  typedef enum logic [1:0] {IDLE, UNI, BCAST, RESP} cluster_state_e;

endpackage

// File: rtl/lagd_cluster_done_agg.sv
// Sticky per-core done status, irq enables, ALL_DONE detection and the
// registered level interrupt.
module lagd_cluster_done_agg #(
  parameter int unsigned NumCores = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumCores-1:0] done_i,
  input  logic [NumCores-1:0] mask_i,
  input  logic [NumCores-1:0] w1c_i,
  input  logic                irq_en_we_i,
  input  logic [1:0]          irq_en_wdata_i,
  output logic [NumCores-1:0] status_o,
  output logic                all_done_o,
  output logic [1:0]          irq_en_o,
  output logic                irq_o
);

  logic [NumCores-1:0] status_d, status_q;
  logic [1:0]          irq_en_d, irq_en_q;
  logic                irq_d, irq_q;

  // A done pulse wins over a clear of the same bit so no completion is lost.
  always_comb begin
    status_d = (status_q & ~w1c_i) | done_i;
    irq_en_d = irq_en_we_i ? irq_en_wdata_i : irq_en_q;
  end

  assign all_done_o = (mask_i != '0) && ((status_q & mask_i) == mask_i);

  // Interrupt is computed from the current registers, so it lags them by one cycle.
  always_comb begin
    irq_d = (irq_en_q[0] && (|status_q)) || (irq_en_q[1] && all_done_o);
  end

  // Status, enable and interrupt registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign status_o = status_q;
  assign irq_en_o = irq_en_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/lagd_ising_cluster_ctrl.sv
// Cluster register front end: decodes host accesses into unicast, broadcast
// (under MASK) or local CSR accesses, with a downstream stall timeout.
module lagd_ising_cluster_ctrl #(
  parameter int unsigned NumCores      = 4,
  parameter int unsigned CoreSpanW     = 12,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         reg_req_t     = lagd_pkg::reg_req_t,
  parameter type         reg_rsp_t     = lagd_pkg::reg_rsp_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  reg_req_t                 reg_req_i,
  output reg_rsp_t                 reg_rsp_o,
  output reg_req_t [NumCores-1:0]  core_req_o,
  input  reg_rsp_t [NumCores-1:0]  core_rsp_i,
  input  logic [NumCores-1:0]      core_done_i,
  output logic                     irq_o,
  output logic                     busy_o
);
  import lagd_pkg::*;

  localparam int unsigned   IdxW     = $clog2(NumCores + 2);
  localparam int unsigned   CntW     = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [IdxW-1:0] SelCsr   = IdxW'(NumCores);
  localparam logic [IdxW-1:0] SelBcast = IdxW'(NumCores + 1);

  cluster_state_e      state_d, state_q;
  reg_req_t            req_d, req_q;
  reg_rsp_t            rsp_d, rsp_q;
  reg_rsp_t            uni_rsp;
  logic [IdxW-1:0]     sel_d, sel_q, sel_in;
  logic [NumCores-1:0] pending_d, pending_q;
  logic [NumCores-1:0] mask_d, mask_q;
  logic [CntW-1:0]     cnt_d, cnt_q;
  logic [CoreSpanW-1:0] off_in;
  logic [NumCores-1:0] w1c, status;
  logic [1:0]          irq_en;
  logic                irq_en_we, all_done, we_in, tmo;

  assign sel_in = reg_req_i.addr[CoreSpanW +: IdxW];
  assign off_in = reg_req_i.addr[CoreSpanW-1:0];
  // wstrb[0] low turns a local write into a plain access with no side effect.
  assign we_in  = reg_req_i.write && reg_req_i.wstrb[0];
  assign tmo    = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));

  // Response of the addressed core while in a unicast transfer.
  always_comb begin
    uni_rsp = '0;
    for (int i = 0; i < NumCores; i++)
      if (sel_q == IdxW'(i)) uni_rsp = core_rsp_i[i];
  end

  // Next-state, decode, local CSR access and response capture.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_d       = rsp_q;
    rsp_d.ready = 1'b0;
    sel_d       = sel_q;
    pending_d   = pending_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    w1c         = '0;
    irq_en_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reg_req_i.valid) begin
          req_d       = reg_req_i;
          sel_d       = sel_in;
          cnt_d       = '0;
          rsp_d.rdata = '0;
          rsp_d.error = 1'b0;
          if (sel_in < SelCsr) begin
            state_d = UNI;
          end else if (sel_in == SelCsr) begin
            state_d = RESP;
            case (off_in)
              CoreSpanW'(CsrMaskOff): begin
                rsp_d.rdata[NumCores-1:0] = mask_q;
                if (we_in) mask_d = reg_req_i.wdata[NumCores-1:0];
              end
              CoreSpanW'(CsrStatusOff): begin
                rsp_d.rdata[NumCores:0] = {all_done, status};
                if (we_in) w1c = reg_req_i.wdata[NumCores-1:0];
              end
              CoreSpanW'(CsrIrqEnOff): begin
                rsp_d.rdata[1:0] = irq_en;
                irq_en_we        = we_in;
              end
              default: rsp_d.error = 1'b1;
            endcase
          end else if (sel_in == SelBcast && reg_req_i.write && mask_q != '0) begin
            pending_d = mask_q;
            state_d   = BCAST;
          end else begin
            // Broadcast read, broadcast with empty mask, or unmapped window.
            rsp_d.error = 1'b1;
            state_d     = RESP;
          end
        end
      end
      UNI: begin
        cnt_d = cnt_q + CntW'(1);
        if (uni_rsp.ready) begin
          rsp_d.rdata = uni_rsp.rdata;
          rsp_d.error = uni_rsp.error;
          state_d     = RESP;
        end else if (tmo) begin
          rsp_d.rdata = '0;
          rsp_d.error = 1'b1;
          state_d     = RESP;
        end
      end
      BCAST: begin
        cnt_d = cnt_q + CntW'(1);
        for (int i = 0; i < NumCores; i++) begin
          if (pending_q[i] && core_rsp_i[i].ready) begin
            pending_d[i] = 1'b0;
            rsp_d.error  = rsp_d.error | core_rsp_i[i].error;
          end
        end
        if (pending_d == '0) begin
          rsp_d.rdata = '0;
          state_d     = RESP;
        end else if (tmo) begin
          pending_d   = '0;
          rsp_d.rdata = '0;
          rsp_d.error = 1'b1;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Downstream requests: shared payload, offset-only address, valid from state.
  always_comb begin
    for (int i = 0; i < NumCores; i++) begin
      core_req_o[i]                      = req_q;
      core_req_o[i].addr                 = '0;
      core_req_o[i].addr[CoreSpanW-1:0]  = req_q.addr[CoreSpanW-1:0];
      core_req_o[i].valid = (state_q == UNI && sel_q == IdxW'(i)) ||
                            (state_q == BCAST && pending_q[i]);
    end
  end

  // Upstream response is registered; ready is a one-cycle pulse in RESP.
  always_comb begin
    reg_rsp_o       = rsp_q;
    reg_rsp_o.ready = (state_q == RESP);
  end

  assign busy_o = (state_q != IDLE);

  // Control and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rsp_q     <= '0;
      sel_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rsp_q     <= rsp_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
    end
  end

  lagd_cluster_done_agg #(.NumCores(NumCores)) i_done_agg (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .done_i         (core_done_i),
    .mask_i         (mask_q),
    .w1c_i          (w1c),
    .irq_en_we_i    (irq_en_we),
    .irq_en_wdata_i (reg_req_i.wdata[1:0]),
    .status_o       (status),
    .all_done_o     (all_done),
    .irq_en_o       (irq_en),
    .irq_o          (irq_o)
  );

endmodule

// File: tb/tb_lagd_ising_cluster_ctrl.sv
// Directed bench for the cluster front end with a simple delayed-ready core model.
module tb_lagd_ising_cluster_ctrl;
  import lagd_pkg::*;

  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  reg_req_t req;
  reg_rsp_t rsp;
  reg_req_t [NC-1:0] creq;
  reg_rsp_t [NC-1:0] crsp;
  logic [NC-1:0] done;
  logic irq, busy;

  lagd_ising_cluster_ctrl #(.NumCores(NC), .CoreSpanW(12), .TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_rsp_o(rsp),
    .core_req_o(creq), .core_rsp_i(crsp), .core_done_i(done),
    .irq_o(irq), .busy_o(busy));

  always #5 clk = ~clk;

  // core model: ready after dly[i] valid cycles, never if never[i]
  int dly [NC];
  logic [NC-1:0] never, cerr;
  int vcnt [NC];

  always @(posedge clk)
    for (int i = 0; i < NC; i++) vcnt[i] <= creq[i].valid ? vcnt[i] + 1 : 0;

  always_comb
    for (int i = 0; i < NC; i++) begin
      crsp[i].rdata = 32'hC0DE_0000 | 32'(i);
      crsp[i].error = cerr[i];
      crsp[i].ready = creq[i].valid && !never[i] && (vcnt[i] == dly[i]);
    end

  // monitor: accumulating counters sampled mid-cycle
  int cyc, up_cnt, up_cyc;
  int vcyc [NC];
  int hs_cnt [NC];
  int hs_cyc [NC];
  logic [31:0] hs_addr [NC];
  logic [31:0] hs_wdata [NC];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rsp.ready) begin up_cnt <= up_cnt + 1; up_cyc <= cyc; end
    for (int i = 0; i < NC; i++) begin
      if (creq[i].valid) vcyc[i] <= vcyc[i] + 1;
      if (creq[i].valid && crsp[i].ready) begin
        hs_cnt[i]   <= hs_cnt[i] + 1;
        hs_cyc[i]   <= cyc;
        hs_addr[i]  <= creq[i].addr;
        hs_wdata[i] <= creq[i].wdata;
      end
    end
  end

  int n_chk, n_fail;
  int v0 [NC];
  int h0 [NC];
  int u0;
  logic busy_at_rdy;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [NC-1:0] cvld();
    for (int i = 0; i < NC; i++) cvld[i] = creq[i].valid;
  endfunction

  function automatic int vd_sum();
    int s = 0;
    for (int i = 0; i < NC; i++) s += vcyc[i] - v0[i];
    return s;
  endfunction

  // one host access, started and finished on a negedge; dp pulses core_done_i
  task automatic acc(input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [3:0] st, input logic [NC-1:0] dp,
                     output logic [31:0] rd, output logic er);
    logic seen = 1'b0;
    for (int i = 0; i < NC; i++) begin v0[i] = vcyc[i]; h0[i] = hs_cnt[i]; end
    u0 = up_cnt;
    rd = '0; er = 1'b0;
    req.addr = a; req.write = w; req.wdata = wd; req.wstrb = st; req.valid = 1'b1;
    done = dp;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      done = '0;
      if (rsp.ready) begin
        seen = 1'b1; rd = rsp.rdata; er = rsp.error; busy_at_rdy = busy;
      end
    end
    req.valid = 1'b0;
    chk("acc_ready", 32'(seen), 1);
    @(negedge clk);
  endtask

  task automatic pulse(input logic [NC-1:0] dp);
    done = dp;
    @(negedge clk);
    done = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0 want 0x1");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic er;
    req = '0; done = '0; never = '0; cerr = '0;
    for (int i = 0; i < NC; i++) dly[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_ready", 32'(rsp.ready), 0);
    chk("rst_err", 32'(rsp.error), 0);
    chk("rst_cvld", 32'(cvld()), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // unicast write to core 2, ready after 3 waits
    dly[2] = 3;
    acc(32'h2010, 1'b1, 32'hDEAD_BEEF, 4'hF, '0, rd, er);
    chk("uni_err", 32'(er), 0);
    chk("uni_hs", hs_cnt[2] - h0[2], 1);
    chk("uni_addr", hs_addr[2], 32'h010);
    chk("uni_wdata", hs_wdata[2], 32'hDEAD_BEEF);
    chk("uni_lat", up_cyc - hs_cyc[2], 1);
    chk("uni_vcyc", vcyc[2] - v0[2], 4);
    chk("uni_others", (vcyc[0] - v0[0]) + (vcyc[1] - v0[1]) + (vcyc[3] - v0[3]), 0);
    dly[2] = 0;

    // unicast read from core 0
    acc(32'h0004, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("uni_rd_data", rd, 32'hC0DE_0000);
    chk("uni_rd_addr", hs_addr[0], 32'h004);

    // MASK write with upper bits set, readback truncated
    acc(32'h4000, 1'b1, 32'hFFFF_FFFB, 4'hF, '0, rd, er);
    chk("mask_wr_err", 32'(er), 0);
    acc(32'h4000, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("mask_rd", rd, 32'hB);
    acc(32'h4000, 1'b1, 32'h3, 4'hE, '0, rd, er);
    acc(32'h4000, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("mask_wstrb", rd, 32'hB);

    // broadcast write under MASK=1011
    dly[0] = 1; dly[1] = 4; dly[3] = 2;
    acc(32'h5020, 1'b1, 32'h5, 4'hF, '0, rd, er);
    chk("bc_err", 32'(er), 0);
    chk("bc_v0", vcyc[0] - v0[0], 2);
    chk("bc_v1", vcyc[1] - v0[1], 5);
    chk("bc_v2", vcyc[2] - v0[2], 0);
    chk("bc_v3", vcyc[3] - v0[3], 3);
    chk("bc_up_once", up_cnt - u0, 1);
    chk("bc_lat", up_cyc - hs_cyc[1], 1);
    chk("bc_wdata", hs_wdata[3], 32'h5);
    chk("bc_addr", hs_addr[0], 32'h020);
    cerr[1] = 1'b1;
    acc(32'h5020, 1'b1, 32'h5, 4'hF, '0, rd, er);
    chk("bc_err_or", 32'(er), 1);
    cerr[1] = 1'b0;
    for (int i = 0; i < NC; i++) dly[i] = 0;

    // error paths
    acc(32'h5020, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("bc_rd_err", 32'(er), 1);
    chk("bc_rd_novld", vd_sum(), 0);
    acc(32'h6000, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("badsel_err", 32'(er), 1);
    acc(32'h400C, 1'b1, 32'h1, 4'hF, '0, rd, er);
    chk("badoff_err", 32'(er), 1);
    chk("badoff_rd", rd, 0);
    acc(32'h4000, 1'b1, 32'h0, 4'hF, '0, rd, er);
    acc(32'h5020, 1'b1, 32'h5, 4'hF, '0, rd, er);
    chk("bc_mask0_err", 32'(er), 1);
    chk("bc_mask0_novld", vd_sum(), 0);

    // done aggregation and irq
    acc(32'h4000, 1'b1, 32'h3, 4'hF, '0, rd, er);
    acc(32'h4008, 1'b1, 32'h2, 4'hF, '0, rd, er);
    acc(32'h4008, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("irqen_rd", rd, 32'h2);
    pulse(4'b0001);
    repeat (2) @(negedge clk);
    chk("irq_partial", 32'(irq), 0);
    pulse(4'b0010);
    chk("irq_lag", 32'(irq), 0);
    @(negedge clk);
    chk("irq_alldone", 32'(irq), 1);
    acc(32'h4004, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("status_rd", rd, 32'h13);
    acc(32'h4004, 1'b1, 32'h1, 4'hF, 4'b0001, rd, er);
    acc(32'h4004, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("w1c_vs_set", rd, 32'h13);
    acc(32'h4000, 1'b1, 32'h4, 4'hF, '0, rd, er);
    acc(32'h4004, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("mask_keeps_status", rd, 32'h03);
    chk("irq_drop", 32'(irq), 0);
    acc(32'h4004, 1'b1, 32'hF, 4'hF, '0, rd, er);
    acc(32'h4004, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("w1c_all", rd, 32'h0);
    acc(32'h4008, 1'b1, 32'h1, 4'hF, '0, rd, er);
    pulse(4'b0100);
    chk("irq_core_lag", 32'(irq), 0);
    @(negedge clk);
    chk("irq_core", 32'(irq), 1);
    acc(32'h4004, 1'b1, 32'h4, 4'hF, '0, rd, er);
    @(negedge clk);
    chk("irq_core_clr", 32'(irq), 0);
    acc(32'h4008, 1'b1, 32'h0, 4'hF, '0, rd, er);

    // timeout on a core that never answers
    never[1] = 1'b1;
    acc(32'h1000, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("tmo_err", 32'(er), 1);
    chk("tmo_rdata", rd, 0);
    chk("tmo_vcyc", vcyc[1] - v0[1], 16);
    chk("tmo_busy_resp", 32'(busy_at_rdy), 1);
    chk("tmo_busy_after", 32'(busy), 0);

    // reset in the middle of a broadcast
    never = '1;
    acc(32'h4000, 1'b1, 32'hF, 4'hF, '0, rd, er);
    pulse(4'b1000);
    req.addr = 32'h5020; req.write = 1'b1; req.wdata = 32'h7; req.wstrb = 4'hF; req.valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstbc_vld", 32'(cvld()), 32'hF);
    chk("rstbc_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbc_vld_clr", 32'(cvld()), 0);
    chk("rstbc_busy_clr", 32'(busy), 0);
    chk("rstbc_ready", 32'(rsp.ready), 0);
    req.valid = 1'b0;
    @(negedge clk);
    u0 = up_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstbc_no_ready", up_cnt - u0, 0);
    never = '0;
    acc(32'h4000, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("rst_mask", rd, 0);
    acc(32'h4004, 1'b0, 32'h0, 4'hF, '0, rd, er);
    chk("rst_status", rd, 0);
    chk("rst_irq_after", 32'(irq), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
